// File: rtl/axi_mem_bridge.sv
// ---------------------------------------------------------------------------
// axi_mem_bridge
//   Bridges an instruction-fetch port (IFU, burst reads) and a load/store port
//   (LSU, single-beat reads and writes) onto one AXI4 master. One transaction
//   is in flight at a time; IFU uses AXI ID 0, LSU uses AXI ID 1.
//
// Build option:
//   AXI_MEM_BRIDGE_RR_EN  defined   -> round-robin arbitration, the last
//                                      granted port loses the next tie
//                         undefined -> LSU has fixed priority over IFU
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ifu_req/addr/len      IFU burst read request (len = beats-1, INCR)
//   ifu_gnt               request accepted (one-cycle pulse, IDLE only)
//   ifu_rvalid/rdata/rlast/err   read beats forwarded from the R channel
//   lsu_req/we/addr/wdata/wstrb/size   LSU single-beat request
//   lsu_gnt               request accepted (one-cycle pulse, IDLE only)
//   lsu_done/rdata/err    completion pulse with read data / error flag
//   io_master_*           AXI4 master aw/w/b/ar/r channels
// ---------------------------------------------------------------------------
module axi_mem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    input  logic [7:0]        ifu_len,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rlast,
    output logic              ifu_err,

    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    input  logic [2:0]        lsu_size,
    output logic              lsu_gnt,
    output logic              lsu_done,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,

    output logic              io_master_awvalid,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [ID_W-1:0]   io_master_awid,
    output logic [7:0]        io_master_awlen,
    output logic [2:0]        io_master_awsize,
    output logic [1:0]        io_master_awburst,
    input  logic              io_master_awready,

    output logic              io_master_wvalid,
    output logic [DATA_W-1:0] io_master_wdata,
    output logic [STRB_W-1:0] io_master_wstrb,
    output logic              io_master_wlast,
    input  logic              io_master_wready,

    output logic              io_master_bready,
    input  logic              io_master_bvalid,
    input  logic [1:0]        io_master_bresp,
    input  logic [ID_W-1:0]   io_master_bid,

    output logic              io_master_arvalid,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [ID_W-1:0]   io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    input  logic              io_master_arready,

    output logic              io_master_rready,
    input  logic              io_master_rvalid,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    input  logic [ID_W-1:0]   io_master_rid
);

    localparam logic [2:0] FULL_SIZE = 3'($clog2(STRB_W));
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_W, WR_A, WR_B} state_t;

    state_t              state;
    logic                owner_lsu;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                lsu_win, r_fire, b_fire;

`ifdef AXI_MEM_BRIDGE_RR_EN
    logic                prefer_lsu;
    assign lsu_win = lsu_req && (!ifu_req || prefer_lsu);
`else
    assign lsu_win = lsu_req;
`endif

    // Grants are combinational so they only ever appear while in IDLE.
    assign lsu_gnt = !reset && (state == IDLE) && lsu_win;
    assign ifu_gnt = !reset && (state == IDLE) && ifu_req && !lsu_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`ifdef AXI_MEM_BRIDGE_RR_EN
            prefer_lsu <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (lsu_gnt || ifu_gnt) begin
                    owner_lsu <= lsu_gnt;
                    we_q      <= lsu_gnt && lsu_we;
                    addr_q    <= lsu_gnt ? lsu_addr : ifu_addr;
                    len_q     <= lsu_gnt ? 8'd0 : ifu_len;
                    size_q    <= lsu_gnt ? lsu_size : FULL_SIZE;
                    wdata_q   <= lsu_gnt ? lsu_wdata : '0;
                    wstrb_q   <= lsu_gnt ? lsu_wstrb : '0;
`ifdef AXI_MEM_BRIDGE_RR_EN
                    prefer_lsu <= !lsu_gnt;
`endif
                    if (lsu_gnt && lsu_we) begin
                        state     <= WR_AW;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                    end else begin
                        state     <= RD_A;
                        arvalid_q <= 1'b1;
                    end
                end
                RD_A: if (io_master_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= RD_D;
                end
                RD_D: if (io_master_rvalid && (owner_lsu || io_master_rlast)) begin
                    rready_q <= 1'b0;
                    state    <= IDLE;
                end
                WR_AW: begin
                    if (io_master_awready) awvalid_q <= 1'b0;
                    if (io_master_wready)  wvalid_q  <= 1'b0;
                    if (io_master_awready && io_master_wready) begin
                        bready_q <= 1'b1;
                        state    <= WR_B;
                    end else if (io_master_awready) begin
                        state <= WR_W;
                    end else if (io_master_wready) begin
                        state <= WR_A;
                    end
                end
                WR_W: if (io_master_wready) begin
                    wvalid_q <= 1'b0;
                    bready_q <= 1'b1;
                    state    <= WR_B;
                end
                WR_A: if (io_master_awready) begin
                    awvalid_q <= 1'b0;
                    bready_q  <= 1'b1;
                    state     <= WR_B;
                end
                WR_B: if (io_master_bvalid) begin
                    bready_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = ID_W'(owner_lsu);
    assign io_master_arlen   = len_q;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = BURST_INCR;
    assign io_master_rready  = rready_q;

    assign io_master_awvalid = awvalid_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = ID_W'(owner_lsu);
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = size_q;
    assign io_master_awburst = BURST_INCR;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_bready  = bready_q;

    // Beats and responses are forwarded in the handshake cycle itself.
    assign r_fire = !reset && rready_q && io_master_rvalid;
    assign b_fire = !reset && bready_q && io_master_bvalid;

    assign ifu_rvalid = r_fire && !owner_lsu;
    assign ifu_rdata  = io_master_rdata;
    assign ifu_rlast  = ifu_rvalid && io_master_rlast;
    assign ifu_err    = ifu_rvalid && (io_master_rresp != 2'b00);

    assign lsu_done  = (r_fire && owner_lsu) || b_fire;
    assign lsu_rdata = io_master_rdata;
    assign lsu_err   = (r_fire && owner_lsu && (io_master_rresp != 2'b00)) ||
                       (b_fire && (io_master_bresp != 2'b00));

    // Response IDs are implied by the single outstanding transaction.
    logic unused_ok;
    assign unused_ok = ^{io_master_rid, io_master_bid, we_q};

endmodule

// File: tb/tb_axi_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_bridge
//   Self-checking bench for axi_mem_bridge. The bench plays both requesters
//   and the AXI slave, with randomized slave latencies and data, and derives
//   every expected value from the bridge's behavioural rules (ownership,
//   burst length, sizes, arbitration winner, error mapping).
// ---------------------------------------------------------------------------
module tb_axi_mem_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;
    localparam logic [2:0] FULL_SIZE = (DW == 64) ? 3'd3 : 3'd2;

    logic          clock = 1'b0;
    logic          reset;
    logic          ifu_req;
    logic [AW-1:0] ifu_addr;
    logic [7:0]    ifu_len;
    logic          ifu_gnt, ifu_rvalid, ifu_rlast, ifu_err;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req, lsu_we;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [SW-1:0] lsu_wstrb;
    logic [2:0]    lsu_size;
    logic          lsu_gnt, lsu_done, lsu_err;
    logic [DW-1:0] lsu_rdata;
    logic          awvalid, awready, wvalid, wready, wlast, bready, bvalid;
    logic [AW-1:0] awaddr, araddr;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic          arvalid, arready, rready, rvalid, rlast;

    int tests = 0;
    int fails = 0;
    bit model_prefer_lsu = 1'b1;

    always #5 clock = ~clock;

    axi_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clock(clock), .reset(reset),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_len(ifu_len), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size), .lsu_gnt(lsu_gnt), .lsu_done(lsu_done),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .io_master_awvalid(awvalid), .io_master_awaddr(awaddr), .io_master_awid(awid),
        .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
        .io_master_awready(awready),
        .io_master_wvalid(wvalid), .io_master_wdata(wdata), .io_master_wstrb(wstrb),
        .io_master_wlast(wlast), .io_master_wready(wready),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
        .io_master_bid(bid),
        .io_master_arvalid(arvalid), .io_master_araddr(araddr), .io_master_arid(arid),
        .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
        .io_master_arready(arready),
        .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rdata(rdata),
        .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Winner when both requesters ask at once.
    function automatic bit tie_winner_lsu();
`ifdef AXI_MEM_BRIDGE_RR_EN
        return model_prefer_lsu;
`else
        return 1'b1;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        ifu_req = 1'b1;
        lsu_req = 1'b1;
        #1;
        tests++;
        if ({ifu_gnt, lsu_gnt} !== 2'b00) begin
            fails++;
            $display("FAIL reset_gnt: got %b want 00", {ifu_gnt, lsu_gnt});
        end
        repeat (3) tick();
        reset = 1'b0;
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        model_prefer_lsu = 1'b1;
        #1;
        tests++;
        if ({arvalid, awvalid, wvalid, bready, rready, ifu_gnt, lsu_gnt, lsu_done,
             ifu_rvalid, ifu_err, lsu_err} !== 11'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0", {arvalid, awvalid, wvalid, bready,
                     rready, ifu_gnt, lsu_gnt, lsu_done, ifu_rvalid, ifu_err, lsu_err});
        end
    endtask

    // Read transaction from the winner's point of view; contend also raises
    // the losing requester with a different address.
    task automatic do_read(input bit is_lsu, input bit contend, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input int err_beat);
        logic [7:0]    exp_len;
        logic [2:0]    exp_size;
        logic [DW-1:0] d;
        logic [AW-1:0] other;
        bit            err, last;
        int            n;
        exp_len  = is_lsu ? 8'd0 : len;
        exp_size = is_lsu ? size : FULL_SIZE;
        other    = ~addr;
        if (is_lsu || contend) begin
            lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = size;
            lsu_addr = is_lsu ? addr : other;
        end
        if (!is_lsu || contend) begin
            ifu_req = 1'b1; ifu_len = len;
            ifu_addr = is_lsu ? other : addr;
        end
        #1;
        tests++;
        if ({lsu_gnt, ifu_gnt} !== {is_lsu, !is_lsu}) begin
            fails++;
            $display("FAIL rd_gnt: got lsu/ifu %b want %b", {lsu_gnt, ifu_gnt}, {is_lsu, !is_lsu});
        end
        model_prefer_lsu = !is_lsu;
        tick();
        ifu_req = 1'b0; lsu_req = 1'b0;
        ifu_addr = $urandom; lsu_addr = $urandom; ifu_len = 8'($urandom); lsu_size = 3'($urandom);
        #1;
        tests++;
        if ({ifu_gnt, lsu_gnt, arvalid, araddr, arlen, arsize, arid, arburst} !==
            {2'b00, 1'b1, addr, exp_len, exp_size, IW'(is_lsu), 2'b01}) begin
            fails++;
            $display("FAIL rd_ar: got v=%b a=%h len=%0d size=%0d id=%0d burst=%b gnt=%b want v=1 a=%h len=%0d size=%0d id=%0d burst=01 gnt=00",
                     arvalid, araddr, arlen, arsize, arid, arburst, {ifu_gnt, lsu_gnt},
                     addr, exp_len, exp_size, is_lsu);
        end
        n = $urandom_range(0, 3);
        repeat (n) begin
            tick();
            tests++;
            if ({arvalid, araddr, rready} !== {1'b1, addr, 1'b0}) begin
                fails++;
                $display("FAIL rd_ar_hold: got v=%b a=%h rready=%b want v=1 a=%h rready=0",
                         arvalid, araddr, rready, addr);
            end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        tests++;
        if ({arvalid, rready} !== 2'b01) begin
            fails++;
            $display("FAIL rd_to_data: got arvalid/rready %b want 01", {arvalid, rready});
        end
        for (int b = 0; b <= int'(exp_len); b++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                tick();
                tests++;
                if ({ifu_rvalid, lsu_done, rready} !== 3'b001) begin
                    fails++;
                    $display("FAIL rd_gap: got ifu_rvalid/lsu_done/rready %b want 001",
                             {ifu_rvalid, lsu_done, rready});
                end
            end
            d    = DW'($urandom);
            err  = (b == err_beat);
            last = (b == int'(exp_len));
            rvalid = 1'b1; rdata = d; rlast = last; rresp = err ? 2'b10 : 2'b00;
            rid = IW'(is_lsu);
            #1;
            tests++;
            if (is_lsu) begin
                if ({lsu_done, lsu_rdata, lsu_err, ifu_rvalid} !== {1'b1, d, err, 1'b0}) begin
                    fails++;
                    $display("FAIL lsu_rd_beat: got done=%b data=%h err=%b ifu_rvalid=%b want done=1 data=%h err=%b ifu_rvalid=0",
                             lsu_done, lsu_rdata, lsu_err, ifu_rvalid, d, err);
                end
            end else begin
                if ({ifu_rvalid, ifu_rdata, ifu_rlast, ifu_err, lsu_done} !==
                    {1'b1, d, last, err, 1'b0}) begin
                    fails++;
                    $display("FAIL ifu_rd_beat%0d: got v=%b data=%h last=%b err=%b lsu_done=%b want v=1 data=%h last=%b err=%b lsu_done=0",
                             b, ifu_rvalid, ifu_rdata, ifu_rlast, ifu_err, lsu_done, d, last, err);
                end
            end
            tick();
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        #1;
        tests++;
        if ({arvalid, rready, ifu_rvalid, lsu_done} !== 4'b0000) begin
            fails++;
            $display("FAIL rd_end_idle: got %b want 0000", {arvalid, rready, ifu_rvalid, lsu_done});
        end
    endtask

    // order: 0 = AW accepted first, 1 = W accepted first, 2 = both together
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [SW-1:0] ws, input logic [2:0] size,
                            input int order, input logic [1:0] resp);
        int n;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = addr; lsu_wdata = wd;
        lsu_wstrb = ws; lsu_size = size;
        #1;
        tests++;
        if ({lsu_gnt, ifu_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL wr_gnt: got lsu/ifu %b want 10", {lsu_gnt, ifu_gnt});
        end
        model_prefer_lsu = 1'b0;
        tick();
        lsu_req = 1'b0; lsu_we = 1'($urandom); lsu_addr = $urandom;
        lsu_wdata = DW'($urandom); lsu_wstrb = SW'($urandom); lsu_size = 3'($urandom);
        #1;
        tests++;
        if ({awvalid, wvalid, arvalid, awaddr, awlen, awsize, awburst, awid, wdata, wstrb, wlast} !==
            {3'b110, addr, 8'd0, size, 2'b01, IW'(1), wd, ws, 1'b1}) begin
            fails++;
            $display("FAIL wr_aw_w: got awv=%b wv=%b arv=%b a=%h len=%0d size=%0d burst=%b id=%0d d=%h s=%h last=%b want 1 1 0 a=%h len=0 size=%0d burst=01 id=1 d=%h s=%h last=1",
                     awvalid, wvalid, arvalid, awaddr, awlen, awsize, awburst, awid, wdata, wstrb,
                     wlast, addr, size, wd, ws);
        end
        n = $urandom_range(0, 2);
        repeat (n) begin
            tick();
            tests++;
            if ({awvalid, wvalid, lsu_done} !== 3'b110) begin
                fails++;
                $display("FAIL wr_hold: got %b want 110", {awvalid, wvalid, lsu_done});
            end
        end
        if (order == 2) begin
            awready = 1'b1; wready = 1'b1;
            tick();
            awready = 1'b0; wready = 1'b0;
        end else begin
            if (order == 0) awready = 1'b1; else wready = 1'b1;
            tick();
            awready = 1'b0; wready = 1'b0;
            #1;
            tests++;
            if ({awvalid, wvalid, bready, lsu_done} !== ((order == 0) ? 4'b0100 : 4'b1000)) begin
                fails++;
                $display("FAIL wr_half_%0d: got %b want %b", order, {awvalid, wvalid, bready, lsu_done},
                         (order == 0) ? 4'b0100 : 4'b1000);
            end
            n = $urandom_range(0, 2);
            repeat (n) tick();
            if (order == 0) wready = 1'b1; else awready = 1'b1;
            tick();
            awready = 1'b0; wready = 1'b0;
        end
        #1;
        tests++;
        if ({awvalid, wvalid, bready, lsu_done} !== 4'b0010) begin
            fails++;
            $display("FAIL wr_b_wait: got %b want 0010", {awvalid, wvalid, bready, lsu_done});
        end
        n = $urandom_range(0, 3);
        repeat (n) begin
            tick();
            tests++;
            if ({bready, lsu_done} !== 2'b10) begin
                fails++;
                $display("FAIL wr_early_done: got bready/done %b want 10", {bready, lsu_done});
            end
        end
        bvalid = 1'b1; bresp = resp; bid = IW'(1);
        #1;
        tests++;
        if ({lsu_done, lsu_err} !== {1'b1, resp != 2'b00}) begin
            fails++;
            $display("FAIL wr_done: got done/err %b want %b", {lsu_done, lsu_err}, {1'b1, resp != 2'b00});
        end
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        tests++;
        if ({bready, lsu_done, lsu_err, awvalid, wvalid} !== 5'b00000) begin
            fails++;
            $display("FAIL wr_end_idle: got %b want 00000", {bready, lsu_done, lsu_err, awvalid, wvalid});
        end
    endtask

    task automatic test_ifu_read();
        do_read(1'b0, 1'b0, 32'h8000_0000, 8'd3, 3'd0, -1);
    endtask

    task automatic test_lsu_write_wfirst();
        do_write(32'h100, 32'hDEAD_BEEF, 4'hF, 3'd2, 1, 2'b00);
    endtask

    task automatic test_arbitration();
        for (int k = 0; k < 2; k++) begin
            do_read(tie_winner_lsu(), 1'b1, 32'h2000 + 32'(k * 16), 8'd0, 3'd2, -1);
        end
    endtask

    task automatic test_lsu_byte_err();
        do_read(1'b1, 1'b0, 32'h0000_0203, 8'd0, 3'd0, 0);
    endtask

    task automatic test_reset_mid_burst();
        ifu_req = 1'b1; ifu_addr = 32'h4000; ifu_len = 8'd7;
        #1;
        tests++;
        if (ifu_gnt !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_gnt: got %b want 1", ifu_gnt);
        end
        model_prefer_lsu = 1'b1;
        tick();
        ifu_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1; rdata = DW'($urandom); rlast = 1'b0; rresp = 2'b00; rid = '0;
            #1;
            tests++;
            if (ifu_rvalid !== 1'b1) begin
                fails++;
                $display("FAIL rst_mid_beat: got %b want 1", ifu_rvalid);
            end
            tick();
            rvalid = 1'b0;
        end
        reset = 1'b1;
        tick();
        #1;
        tests++;
        if ({arvalid, rready, ifu_rvalid, ifu_gnt} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_idle: got %b want 0000", {arvalid, rready, ifu_rvalid, ifu_gnt});
        end
        tick();
        reset = 1'b0;
        rvalid = 1'b1; rlast = 1'b1;
        #1;
        tests++;
        if ({ifu_rvalid, lsu_done, rready, arvalid} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_stale: got %b want 0000", {ifu_rvalid, lsu_done, rready, arvalid});
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        do_read(1'b0, 1'b0, 32'h4100, 8'd1, 3'd0, -1);
    endtask

    task automatic test_back_to_back_random();
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0: do_read(1'b0, 1'b0, AW'($urandom), 8'($urandom_range(0, 7)), 3'd0,
                           $urandom_range(0, 9) - 1);
                1: do_read(1'b1, 1'b0, AW'($urandom), 8'd0, 3'($urandom_range(0, 2)),
                           $urandom_range(0, 1) - 1);
                default: do_write(AW'($urandom), DW'($urandom), SW'($urandom),
                                  3'($urandom_range(0, 2)), $urandom_range(0, 2),
                                  2'($urandom_range(0, 3)));
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ifu_req = 1'b0; ifu_addr = '0; ifu_len = '0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_size = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        tick();
        test_reset();
        test_arbitration();
        test_ifu_read();
        test_lsu_write_wfirst();
        test_lsu_byte_err();
        test_reset_mid_burst();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
